// File: rtl/pcie_phy_pkg.sv
// Shared lane-level definitions for the PHY datapath.
//   LANE_W / BYTE_W / BYTES_PER_WORD : lane word and byte geometry
//   IDL_SYM                          : idle control symbol
//   ser_state_e                      : serializer FSM states
//   pick_byte()                      : byte select from a lane word, either order
package pcie_phy_pkg;

  localparam int unsigned LANE_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = LANE_W / BYTE_W;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  localparam logic [BYTE_W-1:0] IDL_SYM = 8'h7C;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_e;

  // idx counts bytes in emission order; with msb_first the top byte goes first.
  function automatic logic [BYTE_W-1:0] pick_byte(
    input logic [LANE_W-1:0] word,
    input logic [BCNT_W-1:0] idx,
    input logic              msb_first
  );
    logic [BCNT_W-1:0] sel;
    logic [LANE_W-1:0] sh;
    sel = msb_first ? ~idx : idx;
    sh  = word >> {sel, 3'b000};
    return sh[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/lane_word_fifo.sv
// Lane word buffer: DEPTH x LANE_W circular FIFO, synchronous active-high reset.
// Ports:
//   clk     : clock
//   reset   : synchronous reset, empties the buffer
//   push    : write wr_data (ignored when full)
//   wr_data : word to store
//   pop     : discard head word (ignored when empty)
//   rd_data : head word, valid while count != 0
//   count   : number of stored words, 0..DEPTH
module lane_word_fifo
  import pcie_phy_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [LANE_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [LANE_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [LANE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop  && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_word_serializer.sv
// Per-lane word-to-byte serializer. Buffers 32-bit lane words and emits them
// as a gapless 8-bit stream, one byte per clk_4f cycle.
// Ports:
//   clk_4f    : byte-rate clock (only clock)
//   reset     : synchronous, active-high; drops buffered and part-sent words
//   lane_in   : lane word from striping stage
//   valid_in  : lane_in carries a word; accepted when ready_out=1
//   ready_out : buffer has room (combinational)
//   byte_out  : serialized byte
//   valid_out : byte_out carries data
//   k_out     : byte_out is a control (idle) symbol
// Build option: define LANE_SER_IDLE_FILL_EN to drive IDL_SYM with k_out=1
// during idle cycles; otherwise idle is 8'h00 with k_out=0.
module lane_word_serializer
  import pcie_phy_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic               clk_4f,
  input  logic               reset,
  input  logic [LANE_W-1:0]  lane_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [BYTE_W-1:0]  byte_out,
  output logic               valid_out,
  output logic               k_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [BCNT_W-1:0] LAST_B   = BCNT_W'(BYTES_PER_WORD - 1);

`ifdef LANE_SER_IDLE_FILL_EN
  localparam logic [BYTE_W-1:0] IDLE_BYTE = IDL_SYM;
  localparam logic              IDLE_K    = 1'b1;
`else
  localparam logic [BYTE_W-1:0] IDLE_BYTE = '0;
  localparam logic              IDLE_K    = 1'b0;
`endif

  logic [CW-1:0]      count;
  logic [LANE_W-1:0]  head;
  logic               push;
  logic               pop;
  logic               empty;

  ser_state_e         state, state_nx;
  logic [LANE_W-1:0]  shreg, shreg_nx;
  logic [BCNT_W-1:0]  bcnt, bcnt_nx;
  logic [BYTE_W-1:0]  byte_nx;
  logic               valid_nx;
  logic               k_nx;

  assign ready_out = (count < FULL_CNT);
  assign push      = valid_in && ready_out;
  assign empty     = (count == '0);

  lane_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_4f),
    .reset   (reset),
    .push    (push),
    .wr_data (lane_in),
    .pop     (pop),
    .rd_data (head),
    .count   (count)
  );

  // Output byte is registered: the byte for the word loaded on an edge is
  // presented right after that same edge, which keeps word boundaries gapless.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bcnt_nx  = bcnt;
    pop      = 1'b0;
    byte_nx  = IDLE_BYTE;
    valid_nx = 1'b0;
    k_nx     = IDLE_K;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          bcnt_nx  = '0;
          byte_nx  = pick_byte(head, '0, MSB_FIRST);
          valid_nx = 1'b1;
          k_nx     = 1'b0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bcnt != LAST_B) begin
          bcnt_nx  = bcnt + 1'b1;
          byte_nx  = pick_byte(shreg, bcnt_nx, MSB_FIRST);
          valid_nx = 1'b1;
          k_nx     = 1'b0;
        end else if (!empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          bcnt_nx  = '0;
          byte_nx  = pick_byte(head, '0, MSB_FIRST);
          valid_nx = 1'b1;
          k_nx     = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      byte_out  <= '0;
      valid_out <= 1'b0;
      k_out     <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bcnt      <= bcnt_nx;
      byte_out  <= byte_nx;
      valid_out <= valid_nx;
      k_out     <= k_nx;
    end
  end

endmodule

// File: tb/tb_lane_word_serializer.sv
// Bench for lane_word_serializer: one LSB-first and one MSB-first instance
// share stimulus; per-instance byte queues are filled on accepted pushes and
// drained by a negedge monitor.
module tb_lane_word_serializer;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] lane_in = '0;
  logic        valid_in = 1'b0;

  logic        a_ready, a_valid, a_k;
  logic [7:0]  a_byte;
  logic        b_ready, b_valid, b_k;
  logic [7:0]  b_byte;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       rst_last = 1'b1;

`ifdef LANE_SER_IDLE_FILL_EN
  localparam logic [7:0] IDLE_B = 8'h7C;
  localparam logic       IDLE_K = 1'b1;
`else
  localparam logic [7:0] IDLE_B = 8'h00;
  localparam logic       IDLE_K = 1'b0;
`endif

  always #5 clk_4f = ~clk_4f;

  lane_word_serializer #(.DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .lane_in   (lane_in),
    .valid_in  (valid_in),
    .ready_out (a_ready),
    .byte_out  (a_byte),
    .valid_out (a_valid),
    .k_out     (a_k)
  );

  lane_word_serializer #(.DEPTH(2), .MSB_FIRST(1'b1)) dut_msb (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .lane_in   (lane_in),
    .valid_in  (valid_in),
    .ready_out (b_ready),
    .byte_out  (b_byte),
    .valid_out (b_valid),
    .k_out     (b_k)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask

  // Scoreboard input side: expected bytes for every accepted word.
  always @(posedge clk_4f) begin
    rst_last <= reset;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else if (valid_in) begin
      if (a_ready) for (int i = 0; i < 4; i++)  qa.push_back(lane_in[8*i +: 8]);
      if (b_ready) for (int i = 3; i >= 0; i--) qb.push_back(lane_in[8*i +: 8]);
    end
  end

  // Monitor: compare each presented byte against the queue head; idle cycles
  // must show the idle symbol (or zero right after reset).
  always @(negedge clk_4f) begin
    logic [7:0] exp_idle;
    logic       exp_k;
    exp_idle = rst_last ? 8'h00 : IDLE_B;
    exp_k    = rst_last ? 1'b0  : IDLE_K;
    if (a_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb_unexpected_byte: got %0h expected none at %0t", a_byte, $time);
      end else begin
        check("lsb_byte", {24'h0, a_byte}, {24'h0, qa.pop_front()});
        check("lsb_k_data", {31'h0, a_k}, 32'h0);
      end
    end else begin
      check("lsb_idle_byte", {24'h0, a_byte}, {24'h0, exp_idle});
      check("lsb_idle_k", {31'h0, a_k}, {31'h0, exp_k});
    end
    if (b_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL msb_unexpected_byte: got %0h expected none at %0t", b_byte, $time);
      end else begin
        check("msb_byte", {24'h0, b_byte}, {24'h0, qb.pop_front()});
        check("msb_k_data", {31'h0, b_k}, 32'h0);
      end
    end else begin
      check("msb_idle_byte", {24'h0, b_byte}, {24'h0, exp_idle});
      check("msb_idle_k", {31'h0, b_k}, {31'h0, exp_k});
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  e1 [4];
    logic [7:0]  e5 [4];
    logic [31:0] w2 [3];
    int  accepted;
    logic seen_low, recovered;
    e1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    e5 = '{8'h11, 8'h22, 8'h33, 8'h44};
    w2 = '{32'h03020100, 32'h07060504, 32'h0B0A0908};

    // Reset state
    reset = 1'b1;
    repeat (3) tick;
    check("rst_valid", {31'h0, a_valid}, 32'h0);
    check("rst_byte", {24'h0, a_byte}, 32'h0);
    check("rst_k", {31'h0, a_k}, 32'h0);
    reset = 1'b0;
    tick;
    check("rst_ready", {31'h0, a_ready}, 32'h1);

    // Single word: bytes after edges N+1..N+4, LSB first
    lane_in = 32'hA1B2C3D4; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    check("t1_no_bypass", {31'h0, a_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t1_valid", {31'h0, a_valid}, 32'h1);
      check("t1_byte", {24'h0, a_byte}, {24'h0, e1[k]});
    end
    tick;
    check("t1_valid_after", {31'h0, a_valid}, 32'h0);

    // Words every 4th cycle: gapless 12 bytes, never backpressured
    repeat (3) tick;
    for (int c = 0; c < 13; c++) begin
      if ((c % 4) == 0 && c < 12) begin
        lane_in = w2[c/4]; valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      check("t2_ready", {31'h0, a_ready}, 32'h1);
      tick;
      if (c >= 1) check("t2_gapless_valid", {31'h0, a_valid}, 32'h1);
    end
    valid_in = 1'b0;
    tick;
    check("t2_valid_after", {31'h0, a_valid}, 32'h0);

    // Saturating input: ready drops when full, then recovers at pop rate
    repeat (4) tick;
    accepted = 0; seen_low = 1'b0; recovered = 1'b0;
    for (int i = 0; i < 24; i++) begin
      lane_in = 32'h1000_0000 + i; valid_in = 1'b1;
      if (!a_ready) seen_low = 1'b1;
      else begin
        accepted++;
        if (seen_low) recovered = 1'b1;
      end
      tick;
    end
    valid_in = 1'b0;
    check("t3_ready_dropped", {31'h0, seen_low}, 32'h1);
    check("t3_ready_recovered", {31'h0, recovered}, 32'h1);
    check("t3_accepted", accepted, 8);
    for (int t = 0; t < 100 && (qa.size() != 0 || qb.size() != 0); t++) tick;
    check("t3_drained_lsb", qa.size(), 0);
    check("t3_drained_msb", qb.size(), 0);

    // Reset mid-word with two words buffered
    repeat (2) tick;
    lane_in = 32'hDEADBEEF; valid_in = 1'b1;
    tick;
    lane_in = 32'h55667788;
    tick;
    lane_in = 32'h99AABBCC;
    tick;
    valid_in = 1'b0;
    check("t4_byte1_lsb", {24'h0, a_byte}, 32'hBE);
    check("t4_byte1_msb", {24'h0, b_byte}, 32'hAD);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t4_valid", {31'h0, a_valid}, 32'h0);
    check("t4_byte", {24'h0, a_byte}, 32'h0);
    check("t4_ready", {31'h0, a_ready}, 32'h1);
    for (int t = 0; t < 8; t++) begin
      tick;
      check("t4_stays_idle", {31'h0, a_valid}, 32'h0);
    end

    // MSB-first order on the second instance
    lane_in = 32'h11223344; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    check("t5_no_bypass", {31'h0, b_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t5_valid", {31'h0, b_valid}, 32'h1);
      check("t5_byte", {24'h0, b_byte}, {24'h0, e5[k]});
    end
    tick;
    check("t5_valid_after", {31'h0, b_valid}, 32'h0);
    repeat (3) tick;
    check("end_queue_lsb", qa.size(), 0);
    check("end_queue_msb", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_word_serializer.md
Name: lane_word_serializer

Overview:
- Per-lane stage directly downstream of the byte-striping block.
- Accepts 32-bit lane words, each with a valid flag, at word rate. Emits them as a continuous 8-bit byte stream at 4x rate, ready for the per-lane encoder/serial stage.
- Has a small word buffer so upstream bursts at clk_f phase do not stall.
- One instance per lane.

Parameters:
- DEPTH, 2, word-buffer entries; power of two, at least 2.
- MSB_FIRST, 0, byte order: 0 emits lane_in[7:0] first; 1 emits lane_in[31:24] first.

Ports:
- clk_4f  in  1  byte-rate clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- lane_in  in  32  lane word from the striping stage.
- valid_in  in  1  lane_in carries a valid word.
- ready_out  out  1  buffer can accept a word this cycle.
- byte_out  out  8  serialized byte.
- valid_out  out  1  byte_out carries data.
- k_out  out  1  byte_out is a control (idle) symbol.

Behaviour:
- Clocking and reset: one clock, clk_4f. Reset is synchronous and active-high, named reset. All state updates on posedge clk_4f.
- Reset values: byte_out=0, valid_out=0, k_out=0, buffer empty, byte counter=0, FSM=IDLE, ready_out=1 from the cycle after reset deasserts.
- Reset while a word is part-sent: the remaining bytes and all buffered words are dropped. No partial flush.
- Push: occurs when valid_in && ready_out at a clock edge. When ready_out=0, valid_in is ignored and the word is lost; upstream must hold or drop it.
- ready_out: combinational, equals (count < DEPTH).
- Buffer: circular FIFO with rd/wr pointers of log2(DEPTH) bits, wrapping naturally, plus a count of log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged.
- Push while full: cannot occur, because ready_out=0.
- FSM state IDLE: no word in the shifter.
  - If the buffer is non-empty, pop the head word into the 32-bit shift register and go to SHIFT.
  - The popped word's first byte is driven on the same edge.
- FSM state SHIFT: byte counter bcnt runs 0..3, one byte per cycle, selected by MSB_FIRST.
  - At bcnt=3 with the buffer non-empty: pop the next word and stay in SHIFT with bcnt=0. The stream is gapless.
  - At bcnt=3 with the buffer empty: go to IDLE.
- Latency: a word pushed at edge N into an empty block produces byte0 after edge N+1, and bytes 1, 2, 3 after edges N+2, N+3, N+4.
  - The same-edge push-to-pop bypass is not allowed; the word goes through the buffer.
- Throughput: sustained 1 word per 4 cycles.
  - Offered rate above that fills the buffer. ready_out then drops for the cycles the buffer is full.
- Outputs: valid_out=1 for every shifted byte and 0 in IDLE. When valid_out=0, byte_out holds 0 and k_out=0 (unless IDLE_FILL_EN is defined).

Optional Feature:
- Macro: LANE_SER_IDLE_FILL_EN.
- Defined:
  - In IDLE, byte_out=8'h7C (IDL symbol), k_out=1, valid_out=0.
  - The link always sees a defined symbol.
  - Data bytes always have k_out=0.
- Undefined: k_out is tied 0 and idle byte_out=8'h00.
- Port list is identical either way.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - LANE_W=32 and BYTE_W=8, with BYTES_PER_WORD derived as LANE_W/BYTE_W.
  - IDL_SYM=8'h7C.
  - the FSM state enum {IDLE, SHIFT}.
- Natural sub-module: lane_word_fifo (parameterized DEPTH×LANE_W synchronous FIFO with push/pop/count and the same reset).
- The FSM, shifter and byte select stay in the top module.

Test Plan:
- Reset, then a single push of 32'hA1B2C3D4 (MSB_FIRST=0).
  - Bytes D4, C3, B2, A1 with valid_out=1 on cycles N+1..N+4.
  - Then valid_out=0.
- Words 32'h03020100, 32'h07060504, 32'h0B0A0908 pushed every 4th cycle.
  - Gapless bytes 00..0B.
  - valid_out held 1 for 12 cycles.
  - ready_out never low.
- valid_in held 1 every cycle with incrementing words, DEPTH=2.
  - ready_out drops once the buffer is full, then toggles at the 1-in-4 pop rate.
  - No accepted word is lost or duplicated (scoreboard).
- reset asserted after byte1 of 32'hDEADBEEF, with 2 words buffered.
  - Next cycle valid_out=0 and byte_out=0.
  - Buffer empty and ready_out=1.
  - None of the dropped bytes reappear.
- MSB_FIRST=1 with push 32'h11223344: bytes 11, 22, 33, 44.
- LANE_SER_IDLE_FILL_EN defined: idle cycles show byte_out=7C, k_out=1, valid_out=0; data bytes show k_out=0.
